// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RAW hazard detection, operand forwarding, load-use stall and redirect flush control
module hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [1:0]  LOAD_WB_SEL  = 2'd0,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      i_id_inst,
    input  logic             i_id_valid,
    input  logic [31:0]      i_ex_inst,
    input  logic             i_ex_valid,
    input  logic             i_ex_reg_wr_en,
    input  logic [1:0]       i_ex_wb_sel,
    input  logic             i_ex_pc_sel,
    input  logic [4:0]       i_mem_rd,
    input  logic             i_mem_reg_wr_en,
    output logic             o_stall,
    output logic             o_bubble,
    output logic             o_flush,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t     state;
    logic [3:0] cnt;

    logic [6:0] id_op;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       rs1_used;
    logic       rs2_used;
    logic       ex_wr;
    logic       ex_is_load;
    logic       ex_hit_a;
    logic       ex_hit_b;
    logic       mem_hit_a;
    logic       mem_hit_b;
    logic       load_use;
    logic       taken;
    logic       flushing;
    logic       stall_now;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    logic inst_bits_unused;
    assign inst_bits_unused = ^{i_id_inst[31:25], i_id_inst[14:7], i_ex_inst[31:12], i_ex_inst[6:0]};

    assign id_op    = i_id_inst[6:0];
    assign id_rs1   = i_id_inst[19:15];
    assign id_rs2   = i_id_inst[24:20];
    assign ex_rd    = i_ex_inst[11:7];
    assign rs1_used = (id_op != OP_LUI) && (id_op != OP_AUIPC) && (id_op != OP_JAL);
    assign rs2_used = (id_op == OP_RTYPE) || (id_op == OP_STORE) || (id_op == OP_BRANCH);

    // Hits are qualified by a valid decode slot so an empty ID never forwards or stalls.
    assign ex_wr      = i_ex_valid && i_ex_reg_wr_en;
    assign ex_hit_a   = i_id_valid && rs1_used && (id_rs1 != 5'd0) && (id_rs1 == ex_rd) && ex_wr;
    assign ex_hit_b   = i_id_valid && rs2_used && (id_rs2 != 5'd0) && (id_rs2 == ex_rd) && ex_wr;
    assign mem_hit_a  = i_id_valid && rs1_used && (id_rs1 != 5'd0) && (id_rs1 == i_mem_rd) && i_mem_reg_wr_en;
    assign mem_hit_b  = i_id_valid && rs2_used && (id_rs2 != 5'd0) && (id_rs2 == i_mem_rd) && i_mem_reg_wr_en;
    assign ex_is_load = (i_ex_wb_sel == LOAD_WB_SEL);
    assign load_use   = ex_is_load && (ex_hit_a || ex_hit_b);
    assign taken      = i_ex_valid && i_ex_pc_sel;

    // A redirect always beats a load-use stall; outputs are forced low while reset is held.
    assign flushing  = reset && (taken || (state == FLUSH));
    assign stall_now = reset && load_use && !flushing;
    assign o_flush   = flushing;
    assign o_stall   = stall_now;
    assign o_bubble  = flushing || stall_now;

    always_comb begin
        fwd_a_next = FWD_RF;
        fwd_b_next = FWD_RF;
        if (!o_bubble) begin
            if (ex_hit_a && !ex_is_load) fwd_a_next = FWD_MEM;
            else if (mem_hit_a)          fwd_a_next = FWD_WB;
            if (ex_hit_b && !ex_is_load) fwd_b_next = FWD_MEM;
            else if (mem_hit_b)          fwd_b_next = FWD_WB;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            cnt           <= 4'd0;
            o_fwd_a_sel   <= FWD_RF;
            o_fwd_b_sel   <= FWD_RF;
            o_stall_count <= '0;
            o_flush_count <= '0;
        end else begin
            o_fwd_a_sel <= fwd_a_next;
            o_fwd_b_sel <= fwd_b_next;

            case (state)
                RUN: begin
                    if (taken && (FLUSH_CYCLES > 1)) begin
                        state <= FLUSH;
                        cnt   <= FLUSH_RELOAD;
                    end
                end
                FLUSH: begin
                    if (taken) begin
                        cnt <= FLUSH_RELOAD;
                    end else if (cnt == 4'd1) begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase

            if (stall_now && !(&o_stall_count))
                o_stall_count <= o_stall_count + CNT_W'(1);
            if (flushing && !(&o_flush_count))
                o_flush_count <= o_flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed and randomized checks of hazard_controller against a rule-level model
module tb_hazard_controller;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      id_inst;
    logic             id_valid;
    logic [31:0]      ex_inst;
    logic             ex_valid;
    logic             ex_reg_wr_en;
    logic [1:0]       ex_wb_sel;
    logic             ex_pc_sel;
    logic [4:0]       mem_rd;
    logic             mem_reg_wr_en;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    hazard_controller #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .LOAD_WB_SEL  (2'd0),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_id_inst       (id_inst),
        .i_id_valid      (id_valid),
        .i_ex_inst       (ex_inst),
        .i_ex_valid      (ex_valid),
        .i_ex_reg_wr_en  (ex_reg_wr_en),
        .i_ex_wb_sel     (ex_wb_sel),
        .i_ex_pc_sel     (ex_pc_sel),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_wr_en (mem_reg_wr_en),
        .o_stall         (stall),
        .o_bubble        (bubble),
        .o_flush         (flush),
        .o_fwd_a_sel     (fwd_a_sel),
        .o_fwd_b_sel     (fwd_b_sel),
        .o_stall_count   (stall_count),
        .o_flush_count   (flush_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int checks = 0;

    // Reference model state: remaining flush cycles after the current one, and expected registered values.
    int         m_flush_rem;
    int         m_stall_cnt;
    int         m_flush_cnt;
    logic [1:0] m_fwd_a;
    logic [1:0] m_fwd_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic src_hit(input logic [4:0] src, input logic used,
                                     input logic [4:0] dst, input logic wr);
        return id_valid && used && (src != 5'd0) && (src == dst) && wr;
    endfunction

    function automatic logic [31:0] make_inst(input logic [6:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [9];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        return make_inst(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    endfunction

    task automatic drive_quiet();
        id_inst = 32'd0; id_valid = 1'b0;
        ex_inst = 32'd0; ex_valid = 1'b0; ex_reg_wr_en = 1'b0;
        ex_wb_sel = 2'd1; ex_pc_sel = 1'b0;
        mem_rd = 5'd0; mem_reg_wr_en = 1'b0;
    endtask

    task automatic drive_random();
        id_inst       = rand_inst();
        id_valid      = ($urandom_range(0, 7) != 0);
        ex_inst       = rand_inst();
        ex_valid      = ($urandom_range(0, 7) != 0);
        ex_reg_wr_en  = ($urandom_range(0, 3) != 0);
        ex_wb_sel     = 2'($urandom_range(0, 3));
        ex_pc_sel     = ($urandom_range(0, 5) == 0);
        mem_rd        = 5'($urandom_range(0, 3));
        mem_reg_wr_en = $urandom_range(0, 1) == 1;
    endtask

    task automatic model_reset();
        m_flush_rem = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        m_fwd_a = 2'b00; m_fwd_b = 2'b00;
    endtask

    // Entered just after a rising edge with inputs already driven; leaves just after the next edge.
    task automatic step(input string tag);
        logic [6:0] op;
        logic       ex_wr, ex_load, eha, ehb, mha, mhb, ld_use, tk, e_flush, e_stall, e_bubble;
        logic [1:0] na, nb;
        op      = id_inst[6:0];
        ex_wr   = ex_valid && ex_reg_wr_en;
        ex_load = (ex_wb_sel == 2'd0);
        eha     = src_hit(id_inst[19:15], uses_rs1(op), ex_inst[11:7], ex_wr);
        ehb     = src_hit(id_inst[24:20], uses_rs2(op), ex_inst[11:7], ex_wr);
        mha     = src_hit(id_inst[19:15], uses_rs1(op), mem_rd, mem_reg_wr_en);
        mhb     = src_hit(id_inst[24:20], uses_rs2(op), mem_rd, mem_reg_wr_en);
        ld_use  = ex_load && (eha || ehb);
        tk      = ex_valid && ex_pc_sel;
        e_flush  = tk || (m_flush_rem > 0);
        e_stall  = ld_use && !e_flush;
        e_bubble = e_flush || e_stall;
        na = e_bubble ? 2'b00 : (eha && !ex_load) ? 2'b01 : mha ? 2'b10 : 2'b00;
        nb = e_bubble ? 2'b00 : (ehb && !ex_load) ? 2'b01 : mhb ? 2'b10 : 2'b00;
        #1;
        chk({tag, ".stall"},  32'(stall),  32'(e_stall));
        chk({tag, ".bubble"}, 32'(bubble), 32'(e_bubble));
        chk({tag, ".flush"},  32'(flush),  32'(e_flush));
        @(posedge clk);
        #1;
        if (tk)                   m_flush_rem = FLUSH_CYCLES - 1;
        else if (m_flush_rem > 0) m_flush_rem--;
        if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (e_flush && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        m_fwd_a = na;
        m_fwd_b = nb;
        chk({tag, ".fwd_a"},       32'(fwd_a_sel),   32'(m_fwd_a));
        chk({tag, ".fwd_b"},       32'(fwd_b_sel),   32'(m_fwd_b));
        chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall_cnt));
        chk({tag, ".flush_count"}, 32'(flush_count), 32'(m_flush_cnt));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"},  32'(stall),  32'd0);
        chk({tag, ".bubble"}, 32'(bubble), 32'd0);
        chk({tag, ".flush"},  32'(flush),  32'd0);
        chk({tag, ".fwd"},    32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        chk({tag, ".counts"}, 32'({stall_count, flush_count}), 32'd0);
    endtask

    localparam logic [31:0] SUB_X10 = 32'h40F50533;
    localparam logic [31:0] SLTU_ID = 32'h00A7B833;

    initial begin
        // Reset held with random inputs, including a taken redirect
        reset = 1'b0;
        drive_random();
        ex_valid = 1'b1; ex_pc_sel = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_hold");
        drive_quiet();
        reset = 1'b1;
        step("after_reset");

        // EX result forwarded to rs2
        ex_inst = SUB_X10; ex_valid = 1'b1; ex_reg_wr_en = 1'b1; ex_wb_sel = 2'd1;
        id_inst = SLTU_ID; id_valid = 1'b1;
        step("ex_fwd");
        chk("ex_fwd.b_const", 32'(fwd_b_sel), 32'd1);
        chk("ex_fwd.a_const", 32'(fwd_a_sel), 32'd0);

        // Load-use on rs1, then the load sits in MEM
        ex_inst = make_inst(7'b0000011, 5'd15, 5'd2, 5'd0); ex_wb_sel = 2'd0;
        step("load_use");
        chk("load_use.count_const", 32'(stall_count), 32'd1);
        ex_valid = 1'b0; mem_rd = 5'd15; mem_reg_wr_en = 1'b1;
        step("load_mem");
        chk("load_mem.a_const", 32'(fwd_a_sel), 32'd2);

        // EX priority over MEM, then x0 never matches
        ex_inst = SUB_X10; ex_valid = 1'b1; ex_wb_sel = 2'd1; mem_rd = 5'd10;
        step("ex_over_mem");
        chk("ex_over_mem.b_const", 32'(fwd_b_sel), 32'd1);
        ex_inst = 32'h40F50033; id_inst = 32'h00000033; mem_rd = 5'd0;
        step("x0");
        chk("x0.const", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);

        // Taken redirect: two flush cycles
        drive_quiet();
        ex_inst = make_inst(7'b1100011, 5'd0, 5'd1, 5'd2); ex_valid = 1'b1; ex_pc_sel = 1'b1;
        step("taken0");
        drive_quiet();
        step("taken1");
        step("taken_done");
        chk("taken.flush_count_const", 32'(flush_count), 32'd2);

        // Taken with a simultaneous load-use: flush only
        ex_inst = make_inst(7'b0000011, 5'd15, 5'd2, 5'd0); ex_valid = 1'b1;
        ex_reg_wr_en = 1'b1; ex_wb_sel = 2'd0; ex_pc_sel = 1'b1;
        id_inst = SLTU_ID; id_valid = 1'b1;
        step("taken_ld");
        drive_quiet();
        step("taken_ld1");
        chk("taken_ld.stall_count_const", 32'(stall_count), 32'd1);

        // Reset mid-flush aborts immediately
        ex_valid = 1'b1; ex_pc_sel = 1'b1;
        step("pre_abort");
        drive_quiet();
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("abort_run");

        // Randomized traffic long enough to saturate the counters
        for (int i = 0; i < 300; i++) begin
            drive_random();
            step("rand");
        end
        chk("sat.flush_count", 32'(flush_count), 32'(CNT_MAX));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
